// File: rtl/alu_mc.sv
// Multi-cycle ALU: logic, arithmetic and shift ops finish one edge after accept; MULTU/DIVU take WIDTH+1 edges.
// One operation in flight; the result is held in DONE until out_ready, and in_ready is high only in IDLE.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             overflow,
  output logic             zero
);

  localparam int LW = $clog2(WIDTH);
  localparam logic [LW:0] CNT_LAST = {1'b0, {LW{1'b1}}};
  localparam logic [LW:0] CNT_ONE  = {{LW{1'b0}}, 1'b1};

  localparam logic [3:0] OP_AND  = 4'h0, OP_OR   = 4'h1, OP_ADD  = 4'h2, OP_XOR  = 4'h3;
  localparam logic [3:0] OP_NOTA = 4'h4, OP_NOR  = 4'h5, OP_SUB  = 4'h6, OP_SLTU = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8, OP_SLL  = 4'h9, OP_SRL  = 4'hA, OP_SRA  = 4'hB;
  localparam logic [3:0] OP_MULU = 4'hC, OP_DIVU = 4'hD;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [LW:0]      cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic [WIDTH-1:0] sum, dif, res, it_hi, it_lo;
  logic [WIDTH:0]   madd, shl, dsub;
  logic [LW-1:0]    shamt;
  logic             ovf, is_long, last;

  assign y       = lo_q;
  assign y_hi    = hi_q;
  assign sum     = a + b;
  assign dif     = a - b;
  assign shamt   = b[LW-1:0];
  assign is_long = (op == OP_MULU) || (op == OP_DIVU);
  assign last    = (cnt == CNT_LAST);

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD: begin
        res = sum;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  res = a ^ b;
      OP_NOTA: res = ~a;
      OP_NOR:  res = ~(a | b);
      OP_SUB: begin
        res = dif;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  res = a << shamt;
      OP_SRL:  res = a >> shamt;
      OP_SRA:  res = $unsigned($signed(a) >>> shamt);
      default: res = '0;
    endcase
  end

  // hi_q:lo_q is the product accumulator for MULTU, remainder:quotient for DIVU.
  assign madd = {1'b0, hi_q} + {1'b0, a_q};
  assign shl  = {hi_q, lo_q[WIDTH-1]};
  assign dsub = shl - {1'b0, b_q};

  always_comb begin
    it_hi = hi_q;
    it_lo = lo_q;
    if (op_q == OP_MULU) begin
      if (lo_q[0]) {it_hi, it_lo} = {madd, lo_q[WIDTH-1:1]};
      else         {it_hi, it_lo} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
    end else if (!dsub[WIDTH]) begin
      it_hi = dsub[WIDTH-1:0];
      it_lo = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      it_hi = shl[WIDTH-1:0];
      it_lo = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = is_long ? BUSY : DONE;
      BUSY:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q <= op;
          a_q  <= a;
          b_q  <= b;
          cnt  <= '0;
          hi_q <= '0;
          if (is_long) begin
            lo_q     <= (op == OP_MULU) ? b : a;
            overflow <= 1'b0;
            zero     <= 1'b0;
          end else begin
            lo_q     <= res;
            overflow <= ovf;
            zero     <= (res == '0);
          end
        end
        BUSY: begin
          hi_q <= it_hi;
          lo_q <= it_lo;
          cnt  <= cnt + CNT_ONE;
          if (last) zero <= (it_lo == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Randomized bench for alu_mc (WIDTH=32) with a behavioural model and a per-cycle compare process.
module tb_alu_mc;

  typedef struct packed {
    logic [31:0] y;
    logic [31:0] hi;
    logic        ovf;
    logic        z;
  } res_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] y, y_hi;
  logic        overflow, zero;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  res_t exp_q[$];
  int   acc_q[$];
  int   lat_q[$];
  bit   seen = 1'b0;
  int   el;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_hi(y_hi), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic res_t mk(input logic [31:0] ry, input logic [31:0] rhi, input logic rovf, input logic rz);
    res_t r;
    r.y = ry; r.hi = rhi; r.ovf = rovf; r.z = rz;
    return r;
  endfunction

  function automatic res_t model(input logic [3:0] m_op, input logic [31:0] ma, input logic [31:0] mb);
    res_t r;
    longint sa, sb, s;
    logic [63:0] p;
    int sh;
    r  = '0;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    sh = int'(mb % 32);
    case (m_op)
      4'h0: r.y = ma & mb;
      4'h1: r.y = ma | mb;
      4'h2: begin r.y = ma + mb; s = sa + sb; r.ovf = (s != longint'($signed(r.y))); end
      4'h3: r.y = ma ^ mb;
      4'h4: r.y = ~ma;
      4'h5: r.y = ~(ma | mb);
      4'h6: begin r.y = ma - mb; s = sa - sb; r.ovf = (s != longint'($signed(r.y))); end
      4'h7: r.y = (ma < mb) ? 32'd1 : 32'd0;
      4'h8: r.y = (sa < sb) ? 32'd1 : 32'd0;
      4'h9: r.y = ma << sh;
      4'hA: r.y = ma >> sh;
      4'hB: r.y = 32'(sa >>> sh);
      4'hC: begin p = {32'b0, ma} * {32'b0, mb}; r.y = p[31:0]; r.hi = p[63:32]; end
      4'hD: begin
        if (mb == 0) begin r.y = '1; r.hi = ma; end
        else         begin r.y = ma / mb; r.hi = ma % mb; end
      end
      default: r.y = '0;
    endcase
    r.z = (r.y == 0);
    return r;
  endfunction

  // Inputs change just after posedge, so at negedge they show what the next edge will sample.
  always @(negedge clk) begin
    if (!resetn) begin
      chk("reset_outs", 72'({in_ready, out_valid, y, y_hi, overflow, zero}), 72'({1'b1, 1'b0, 66'b0}));
      exp_q.delete(); acc_q.delete(); lat_q.delete();
      seen = 1'b0;
    end else begin
      chk("in_ready", 72'(in_ready), 72'(exp_q.size() == 0));
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 72'(out_valid), 72'(0));
      end else begin
        el = cyc - acc_q[0] + 1;
        if (out_valid) begin
          if (!seen) chk("latency", 72'(el), 72'(lat_q[0]));
          seen = 1'b1;
          chk("result", 72'({y, y_hi, overflow, zero}), 72'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front()); void'(acc_q.pop_front()); void'(lat_q.pop_front());
            seen = 1'b0;
          end
        end else if (el >= lat_q[0]) begin
          chk("late_valid", 72'(out_valid), 72'(1));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(op, a, b));
        acc_q.push_back(cyc + 1);
        lat_q.push_back((op == 4'hC || op == 4'hD) ? 33 : 1);
      end
    end
  end

  task automatic xact(input logic [31:0] xa, input logic [31:0] xb, input logic [3:0] xop,
                      input int hold, output res_t r);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("in_ready_timeout", 72'(in_ready), 72'(1));
    in_valid = 1'b1; a = xa; b = xb; op = xop;
    @(posedge clk); #1;
    a = $urandom; b = $urandom; op = 4'($urandom);
    n = 0;
    while (!out_valid && n < 60) begin
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      a = $urandom; b = $urandom;
      n++;
    end
    out_ready = 1'b0;
    if (!out_valid) chk("out_valid_timeout", 72'(out_valid), 72'(1));
    r = mk(y, y_hi, overflow, zero);
    repeat (hold) begin @(posedge clk); #1; a = $urandom; b = $urandom; op = 4'($urandom); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 200));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    chk("pin_add",  72'(model(4'h2, 32'h7FFF_FFFF, 32'h1)), 72'(mk(32'h8000_0000, 0, 1, 0)));
    chk("pin_sub",  72'(model(4'h6, 32'd5, 32'd5)),         72'(mk(0, 0, 0, 1)));
    chk("pin_sra",  72'(model(4'hB, 32'h8000_0000, 32'h24)), 72'(mk(32'hF800_0000, 0, 0, 0)));
    chk("pin_mul",  72'(model(4'hC, 32'hFFFF_FFFF, 32'h2)), 72'(mk(32'hFFFF_FFFE, 32'h1, 0, 0)));
    chk("pin_div",  72'(model(4'hD, 32'd100, 32'd7)),       72'(mk(32'd14, 32'd2, 0, 0)));
    chk("pin_div0", 72'(model(4'hD, 32'd7, 32'd0)),         72'(mk(32'hFFFF_FFFF, 32'd7, 0, 0)));

    xact(32'h7FFF_FFFF, 32'h1, 4'h2, 0, r);
    chk("dut_add", 72'(r), 72'(mk(32'h8000_0000, 0, 1, 0)));
    xact(32'd5, 32'd5, 4'h6, 1, r);
    chk("dut_sub", 72'(r), 72'(mk(0, 0, 0, 1)));
    xact(32'h8000_0000, 32'h24, 4'hB, 0, r);
    chk("dut_sra", 72'(r), 72'(mk(32'hF800_0000, 0, 0, 0)));
    xact(32'hFFFF_FFFF, 32'h2, 4'hC, 0, r);
    chk("dut_mul", 72'(r), 72'(mk(32'hFFFF_FFFE, 32'h1, 0, 0)));
    xact(32'd100, 32'd7, 4'hD, 0, r);
    chk("dut_div", 72'(r), 72'(mk(32'd14, 32'd2, 0, 0)));
    xact(32'd7, 32'd0, 4'hD, 2, r);
    chk("dut_div0", 72'(r), 72'(mk(32'hFFFF_FFFF, 32'd7, 0, 0)));
    xact(32'h1234_5678, 32'h0F0F_0F0F, 4'h3, 5, r);
    chk("dut_backpressure", 72'(r), 72'(mk(32'h1D3B_5977, 0, 0, 0)));
    xact(32'hDEAD_BEEF, 32'h1, 4'hE, 0, r);
    chk("dut_reserved", 72'(r), 72'(mk(0, 0, 0, 1)));

    for (int i = 0; i < 200; i++) begin
      xact(pick(), pick(), 4'($urandom_range(0, 15)), $urandom_range(0, 3), r);
    end

    // Abort a DIVU on its tenth cycle; its result must never appear.
    in_valid = 1'b1; a = 32'd100; b = 32'd7; op = 4'hD;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 resetn = 1'b0;
    #1 chk("abort_outs", 72'({in_ready, out_valid}), 72'(2'b10));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    xact(32'd1, 32'd2, 4'h2, 0, r);
    chk("post_reset_add", 72'(r), 72'(mk(32'd3, 0, 0, 0)));
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
